garage_door_plant: RTL and testbench
====================================

GARAGE_DOOR_PLANT -- requirements
Module: garage_door_plant

Interface
REQ-001 Parameter TRAVEL, default 100, meaning full-open position count; the legal range SHALL be 1..255.
REQ-002 Parameter STEP_DIV, default 4, meaning clock edges of motor drive per position step; the legal range SHALL be 1..255.
REQ-003 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst_n, input, 1 bit: reset that SHALL be synchronous and active-low, sampled on the clk rising edge.
REQ-005 Port up_m, input, 1 bit: motor drive toward open.
REQ-006 Port down_m, input, 1 bit: motor drive toward closed.
REQ-007 Port up_max, output, 1 bit: open limit switch, SHALL be 1 exactly when position == TRAVEL.
REQ-008 Port down_max, output, 1 bit: closed limit switch, SHALL be 1 exactly when position == 0.
REQ-009 Port position, output, 8 bits: current door position, 0 = closed, TRAVEL = open.
REQ-010 Port moving, output, 1 bit: SHALL be 1 when the state is RISING or FALLING.
REQ-011 Port fault, output, 1 bit: SHALL be 1 when the state is FAULT.

Function
REQ-012 The block SHALL implement states STOPPED, RISING, FALLING and FAULT, held in a registered state variable.
- It SHALL model the door and limit switches driven by the garage door controller.
- All outputs SHALL decode combinationally from registered state, position and prescaler, with no added pipeline stage.
REQ-013 STOPPED transitions:
- up_m=1, down_m=0, position<TRAVEL -> RISING.
- down_m=1, up_m=0, position>0 -> FALLING.
- both inputs 1 -> FAULT.
- otherwise stay in STOPPED.
REQ-014 RISING transitions:
- both inputs 1 -> FAULT.
- up_m=0 -> STOPPED.
- the step that makes position==TRAVEL -> STOPPED on the same edge.
- otherwise stay in RISING.
REQ-015 FALLING SHALL mirror RISING, using down_m and the limit position 0.
REQ-016 FAULT SHALL be sticky; only reset exits it.
- Position and prescaler SHALL freeze in FAULT.
REQ-017 Prescaler:
- It SHALL count 0..STEP_DIV-1 on each edge where the state is RISING/FALLING and the matching drive input is sampled 1.
- When it reaches STEP_DIV-1, position SHALL step by ±1 and the prescaler SHALL return to 0.
REQ-018 The prescaler SHALL clear to 0 on any edge that does not advance it, so partial steps are discarded.
- This covers drive release, direction change and limit reached.
REQ-019 Position SHALL saturate: it SHALL never exceed TRAVEL and never go below 0.
- A drive into an asserted limit SHALL leave the state STOPPED and the position unchanged.
REQ-020 A direction reversal (up_m 1->0 and down_m 0->1 on the same edge) SHALL pass through STOPPED for one cycle before entering the new direction.
REQ-021 With the drive held continuously from STOPPED, position SHALL change first at the (STEP_DIV+1)th rising edge after the drive is asserted, then every STEP_DIV edges.
- The extra edge is spent on the STOPPED->RISING/FALLING transition.

Reset
REQ-022 rst_n=0 at a rising edge SHALL force the following, regardless of the current state or inputs:
- state STOPPED, position 0, prescaler 0;
- down_max=1, up_max=0, moving=0, fault=0.
REQ-023 A reset asserted mid-travel or in FAULT SHALL take effect on that same edge.
- Motion SHALL resume only from the edges after rst_n returns to 1.

Verification
REQ-024 The bench SHALL cover the following directed scenarios, using TRAVEL=100 and STEP_DIV=4:
- Reset: rst_n=0 for 2 cycles -> position=0, down_max=1, up_max=0, moving=0, fault=0.
- Full open: up_m=1 held from reset release -> moving=1 after edge 1; position=1 and down_max=0 after edge 5; position=100, up_max=1 and moving=0 after edge 401; then stays at 100.
- Partial step: up_m=1 for 7 edges then 0 -> position=1, prescaler cleared; up_m=1 again -> position=2 exactly 5 edges later.
- Fault: at position 10 drive both up_m=1 and down_m=1 -> fault=1, moving=0 next edge; position holds 10 with any inputs until rst_n=0, then position=0 and fault=0.
- Limit drive: down_m=1 held at position 0 for 20 edges -> position=0, moving=0, down_max=1 throughout.
- Reset mid-travel: rst_n=0 at position 50 while RISING -> position=0, state STOPPED on that edge.

Source files
------------

// File: rtl/garage_door_plant.sv
// Garage door and limit-switch model: registered state, position and prescaler; outputs decode
// combinationally from those registers (no pipeline). Drive inputs are sampled every clk edge, no backpressure.
module garage_door_plant #(
  parameter int TRAVEL   = 100,
  parameter int STEP_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       up_m,
  input  logic       down_m,
  output logic       up_max,
  output logic       down_max,
  output logic [7:0] position,
  output logic       moving,
  output logic       fault
);

  typedef enum logic [1:0] {
    STOPPED,
    RISING,
    FALLING,
    FAULT
  } state_t;

  localparam logic [7:0] TRAVEL_C    = 8'(TRAVEL);
  localparam logic [7:0] PRESC_MAX_C = 8'(STEP_DIV - 1);

  state_t     state_q, state_d;
  logic [7:0] pos_q, pos_d;
  logic [7:0] presc_q, presc_d;
  logic       both_w;
  logic [7:0] pos_inc_w, pos_dec_w;

  assign both_w    = up_m & down_m;
  assign pos_inc_w = pos_q + 8'd1;
  assign pos_dec_w = pos_q - 8'd1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= STOPPED;
      pos_q   <= 8'd0;
      presc_q <= 8'd0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      presc_q <= presc_d;
    end
  end

  // Prescaler defaults to clear: any edge that does not advance it discards the partial step.
  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    presc_d = 8'd0;
    case (state_q)
      STOPPED: begin
        if (both_w)                         state_d = FAULT;
        else if (up_m && pos_q < TRAVEL_C)  state_d = RISING;
        else if (down_m && pos_q != 8'd0)   state_d = FALLING;
      end
      RISING: begin
        if (both_w)       state_d = FAULT;
        else if (!up_m)   state_d = STOPPED;
        else if (presc_q == PRESC_MAX_C) begin
          pos_d = pos_inc_w;
          if (pos_inc_w == TRAVEL_C) state_d = STOPPED;
        end else begin
          presc_d = presc_q + 8'd1;
        end
      end
      FALLING: begin
        if (both_w)       state_d = FAULT;
        else if (!down_m) state_d = STOPPED;
        else if (presc_q == PRESC_MAX_C) begin
          pos_d = pos_dec_w;
          if (pos_dec_w == 8'd0) state_d = STOPPED;
        end else begin
          presc_d = presc_q + 8'd1;
        end
      end
      FAULT: begin
        presc_d = presc_q;
      end
      default: begin
        state_d = STOPPED;
      end
    endcase
  end

  assign position = pos_q;
  assign up_max   = (pos_q == TRAVEL_C);
  assign down_max = (pos_q == 8'd0);
  assign moving   = (state_q == RISING) || (state_q == FALLING);
  assign fault    = (state_q == FAULT);

endmodule

// File: tb/tb_garage_door_plant.sv
// Scoreboard bench: stimulus pushes reference-model expectations, a monitor pops one per clock edge.
module tb_garage_door_plant;

  localparam int T  = 100;
  localparam int SD = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       up_m = 1'b0;
  logic       down_m = 1'b0;
  logic       up_max, down_max, moving, fault;
  logic [7:0] position;

  typedef struct packed {
    logic [7:0] pos;
    logic       up_max;
    logic       down_max;
    logic       moving;
    logic       fault;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // Reference model: direction as -1/0/+1, count of drive edges spent toward the next step.
  int m_pos = 0;
  int m_dir = 0;
  int m_acc = 0;
  bit m_flt = 1'b0;

  garage_door_plant #(.TRAVEL(T), .STEP_DIV(SD)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .up_m     (up_m),
    .down_m   (down_m),
    .up_max   (up_max),
    .down_max (down_max),
    .position (position),
    .moving   (moving),
    .fault    (fault)
  );

  always #5 clk = ~clk;

  task automatic model_edge(input bit r, input bit u, input bit d);
    bit drive;
    if (!r) begin
      m_pos = 0; m_dir = 0; m_acc = 0; m_flt = 1'b0;
    end else if (m_flt) begin
      // sticky until reset
    end else if (u && d) begin
      m_flt = 1'b1; m_dir = 0; m_acc = 0;
    end else if (m_dir == 0) begin
      m_acc = 0;
      if (u && m_pos < T)      m_dir = 1;
      else if (d && m_pos > 0) m_dir = -1;
    end else begin
      drive = (m_dir > 0) ? u : d;
      if (!drive) begin
        m_dir = 0; m_acc = 0;
      end else begin
        m_acc = m_acc + 1;
        if (m_acc == SD) begin
          m_pos = m_pos + m_dir;
          m_acc = 0;
          if (m_pos == T || m_pos == 0) m_dir = 0;
        end
      end
    end
  endtask

  task automatic step(input bit r, input bit u, input bit d);
    exp_t e;
    @(negedge clk);
    rst_n  = r;
    up_m   = u;
    down_m = d;
    model_edge(r, u, d);
    e.pos      = 8'(m_pos);
    e.up_max   = (m_pos == T);
    e.down_max = (m_pos == 0);
    e.moving   = (m_dir != 0);
    e.fault    = m_flt;
    exp_q.push_back(e);
  endtask

  task automatic hold(input bit r, input bit u, input bit d, input int n);
    for (int i = 0; i < n; i++) step(r, u, d);
  endtask

  task automatic chk(input string nm, input int got, input int want);
    n_vec++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, want);
    end
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        n_vec++;
        if (position !== e.pos || up_max !== e.up_max || down_max !== e.down_max ||
            moving !== e.moving || fault !== e.fault) begin
          n_bad++;
          $display("FAIL outputs t=%0t: got pos=%0d up_max=%b down_max=%b moving=%b fault=%b, expected pos=%0d up_max=%b down_max=%b moving=%b fault=%b",
                   $time, position, up_max, down_max, moving, fault,
                   e.pos, e.up_max, e.down_max, e.moving, e.fault);
        end
      end
    end
  end

  initial begin : stimulus
    int seg_len, kind;
    bit r, u, d;

    hold(0, 0, 0, 2);
    settle();
    chk("reset_pos", position, 0);
    chk("reset_down_max", down_max, 1);
    chk("reset_fault", fault, 0);

    // Full open with drive held from reset release, then held past the limit.
    hold(1, 1, 0, 410);
    settle();
    chk("open_pos", position, 100);
    chk("open_up_max", up_max, 1);
    chk("open_moving", moving, 0);

    // Partial step discarded on release.
    hold(0, 0, 0, 1);
    hold(1, 1, 0, 7);
    hold(1, 0, 0, 1);
    settle();
    chk("partial_pos1", position, 1);
    hold(1, 1, 0, 4);
    settle();
    chk("partial_pos_edge4", position, 1);
    hold(1, 1, 0, 1);
    settle();
    chk("partial_pos2", position, 2);

    // Fault at position 10, sticky under arbitrary inputs.
    hold(0, 0, 0, 1);
    hold(1, 1, 0, 41);
    hold(1, 1, 1, 1);
    for (int i = 0; i < 12; i++) step(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    settle();
    chk("fault_pos", position, 10);
    chk("fault_flag", fault, 1);
    hold(0, 0, 0, 1);
    settle();
    chk("fault_reset_pos", position, 0);
    chk("fault_reset_flag", fault, 0);

    // Drive into the closed limit.
    hold(1, 0, 1, 20);
    settle();
    chk("limit_pos", position, 0);
    chk("limit_moving", moving, 0);

    // Reset mid-travel at position 50, then a direction reversal.
    hold(1, 1, 0, 201);
    settle();
    chk("mid_pos", position, 50);
    hold(0, 1, 0, 1);
    settle();
    chk("mid_reset_pos", position, 0);
    hold(1, 1, 0, 30);
    hold(1, 0, 1, 30);

    // Randomized segments of held inputs.
    for (int s = 0; s < 160; s++) begin
      kind    = $urandom_range(0, 19);
      seg_len = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : $urandom_range(1, 45);
      r = 1'b1; u = 1'b0; d = 1'b0;
      if (kind < 8)        u = 1'b1;
      else if (kind < 15)  d = 1'b1;
      else if (kind == 16) begin u = 1'b1; d = 1'b1; seg_len = 2; end
      else if (kind >= 17) begin r = 1'b0; seg_len = 1; end
      hold(r, u, d, seg_len);
    end

    settle();
    @(posedge clk);
    #2;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
